// File: rtl/filtro_pkg.sv
// Shared types and scaling helper for the parametrised first-order IIR section.
package filtro_pkg;

  typedef enum logic [2:0] {REPOSO, MUL_B0, MUL_B1, MUL_A1, ESCALA, LISTO} estado_t;

  // Widest word the helper supports; the accumulator is sized for three 2W-bit terms.
  localparam int W_MAX     = 32;
  localparam int ACC_W_MAX = 2*W_MAX + 2;

  function automatic int acc_w(input int w);
    return 2*w + 2;
  endfunction

  // Round half up, drop f fraction bits, clamp to a w-bit signed range.
  function automatic logic signed [W_MAX-1:0] sat_redondeo(
    input logic signed [ACC_W_MAX-1:0] acc, input int w, input int f);
    logic signed [ACC_W_MAX-1:0] uno, r, lim_hi, lim_lo;
    uno    = ACC_W_MAX'(1);
    r      = (acc + (uno <<< (f-1))) >>> f;
    lim_hi = (uno <<< (w-1)) - uno;
    lim_lo = -(uno <<< (w-1));
    if (r > lim_hi)      r = lim_hi;
    else if (r < lim_lo) r = lim_lo;
    return r[W_MAX-1:0];
  endfunction

endpackage

// File: rtl/filtro_iir1_param_mac_serie.sv
// Shared signed multiplier with a three-way operand select feeding one accumulator.
module mac_serie #(
  parameter int W     = 25,
  parameter int ACC_W = 2*W + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [1:0]              sel,
  input  logic signed [W-1:0]     k0,
  input  logic signed [W-1:0]     k1,
  input  logic signed [W-1:0]     k2,
  input  logic signed [W-1:0]     x0,
  input  logic signed [W-1:0]     x1,
  input  logic signed [W-1:0]     x2,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [W-1:0]   k, x;
  logic signed [2*W-1:0] prod;

  always_comb begin
    k = k0;
    x = x0;
    case (sel)
      2'd1: begin k = k1; x = x1; end
      2'd2: begin k = k2; x = x2; end
      default: ;
    endcase
  end

  assign prod = k * x;

  always_ff @(posedge clk) begin
    if (rst || clr)  acc <= '0;
    else if (en)     acc <= acc + ACC_W'(prod);
  end
endmodule

// File: rtl/filtro_iir1_param.sv
// First-order IIR y = B0*u + B1*u[n-1] + A1*y[n-1], one multiplier sequenced by an FSM.
module filtro_iir1_param import filtro_pkg::*; #(
  parameter int W  = 25,
  parameter int F  = 16,
  parameter int B0 = 64225,
  parameter int B1 = -64225,
  parameter int A1 = 64225
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic signed [W-1:0] u,
  input  logic                borrar,
  output logic                rx_2,
  output logic signed [W-1:0] y,
  output logic                ocupado
);
  localparam int ACC_W = acc_w(W);
  localparam logic signed [W-1:0] KB0 = W'(B0);
  localparam logic signed [W-1:0] KB1 = W'(B1);
  localparam logic signed [W-1:0] KA1 = W'(A1);

  estado_t                  estado;
  logic signed [W-1:0]      u0, u1, y1;
  logic                     pend;
  logic                     mac_clr, mac_en;
  logic [1:0]               mac_sel;
  logic signed [ACC_W-1:0]  acc;
  logic signed [W_MAX-1:0]  sat_full;
  logic signed [W-1:0]      res;
  logic                     sat_unused;

  assign mac_clr = (estado == REPOSO) && rx;
  assign mac_en  = (estado == MUL_B0) || (estado == MUL_B1) || (estado == MUL_A1);

  always_comb begin
    mac_sel = 2'd0;
    case (estado)
      MUL_B1:  mac_sel = 2'd1;
      MUL_A1:  mac_sel = 2'd2;
      default: mac_sel = 2'd0;
    endcase
  end

  mac_serie #(.W(W), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en), .sel(mac_sel),
    .k0(KB0), .k1(KB1), .k2(KA1), .x0(u0), .x1(u1), .x2(y1), .acc(acc)
  );

  assign sat_full   = sat_redondeo(ACC_W_MAX'(acc), W, F);
  assign res        = sat_full[W-1:0];
  assign sat_unused = ^sat_full[W_MAX-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= REPOSO;
      y       <= '0;
      rx_2    <= 1'b0;
      ocupado <= 1'b0;
      u0      <= '0;
      u1      <= '0;
      y1      <= '0;
      pend    <= 1'b0;
    end else begin
      rx_2 <= 1'b0;
      case (estado)
        REPOSO: begin
          // Clear takes effect before a same-cycle sample reads the history.
          if (borrar) begin u1 <= '0; y1 <= '0; end
          if (rx) begin
            u0      <= u;
            ocupado <= 1'b1;
            estado  <= MUL_B0;
          end
        end
        MUL_B0: begin pend <= pend | borrar; estado <= MUL_B1; end
        MUL_B1: begin pend <= pend | borrar; estado <= MUL_A1; end
        MUL_A1: begin pend <= pend | borrar; estado <= ESCALA; end
        ESCALA: begin
          y <= res;
          // A clear seen mid-computation wins over the history update.
          if (pend || borrar) begin u1 <= '0; y1 <= '0; end
          else begin u1 <= u0; y1 <= res; end
          pend   <= 1'b0;
          estado <= LISTO;
        end
        LISTO: begin
          if (borrar) begin u1 <= '0; y1 <= '0; end
          rx_2    <= 1'b1;
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_filtro_iir1_param.sv
// Bench: default high-pass instance plus a B0=2.0 instance, checked against a per-sample model.
module tb_filtro_iir1_param;
  localparam int W = 25;
  localparam int F = 16;
  localparam logic signed [W-1:0] ONE  = W'(65536);
  localparam logic signed [W-1:0] UMAX = W'(16777215);
  localparam logic signed [W-1:0] UMIN = W'(-16777216);

  logic clk = 1'b0, rst = 1'b1, rx = 1'b0, borrar = 1'b0;
  logic signed [W-1:0] u = '0;
  logic [1:0] r2, oc;
  logic signed [W-1:0] yo [2];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  filtro_iir1_param dut_a (
    .clk(clk), .rst(rst), .rx(rx), .u(u), .borrar(borrar),
    .rx_2(r2[0]), .y(yo[0]), .ocupado(oc[0]));

  filtro_iir1_param #(.W(W), .F(F), .B0(131072), .B1(0), .A1(0)) dut_b (
    .clk(clk), .rst(rst), .rx(rx), .u(u), .borrar(borrar),
    .rx_2(r2[1]), .y(yo[1]), .ocupado(oc[1]));

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Model: the result is computed at the accepting edge; only its visibility is timed.
  longint kb0 [2] = '{64225, 131072};
  longint kb1 [2] = '{-64225, 0};
  longint ka1 [2] = '{64225, 0};
  longint m_u1 [2], m_y1 [2], m_prev [2], m_new [2];
  int cyc = 0, acc_e = -100;

  function automatic longint ref_y(longint uu, longint u1, longint y1, longint b0, longint b1, longint a1);
    longint s, lim;
    lim = 64'sd1 <<< (W-1);
    s = b0*uu + b1*u1 + a1*y1;
    s = (s + (64'sd1 <<< (F-1))) >>> F;
    if (s > lim - 1) s = lim - 1;
    if (s < -lim)    s = -lim;
    return s;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      acc_e = -100;
      for (int d = 0; d < 2; d++) begin
        m_u1[d] = 0; m_y1[d] = 0; m_prev[d] = 0; m_new[d] = 0;
      end
    end else begin
      if (borrar)
        for (int d = 0; d < 2; d++) begin m_u1[d] = 0; m_y1[d] = 0; end
      if (rx && cyc > acc_e + 5) begin
        for (int d = 0; d < 2; d++) begin
          m_prev[d] = m_new[d];
          m_new[d]  = ref_y(longint'(u), m_u1[d], m_y1[d], kb0[d], kb1[d], ka1[d]);
          m_u1[d]   = longint'(u);
          m_y1[d]   = m_new[d];
        end
        acc_e = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rx_2[%0d]@%0d", d, cyc), r2[d], (cyc == acc_e + 5));
        chk($sformatf("ocupado[%0d]@%0d", d, cyc), oc[d], (cyc >= acc_e && cyc < acc_e + 5));
        chk($sformatf("y[%0d]@%0d", d, cyc), yo[d], (cyc >= acc_e + 4) ? m_new[d] : m_prev[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // clr_at / rerx_at: cycles after the accepting edge to pulse borrar / a stray rx (-1 = never).
  task automatic send(input logic signed [W-1:0] v, input int clr_at, input int rerx_at,
                      output longint ya, output longint yb, output int lat, output int busy_n);
    int t;
    bit seen;
    rx = 1'b1; u = v; borrar = (clr_at == 0);
    busy_n = 0; lat = 0; seen = 0; ya = 0; yb = 0; t = 0;
    tick();
    rx = 1'b0; borrar = 1'b0;
    while (!seen && t < 20) begin
      t++;
      if (oc[0]) busy_n++;
      borrar = (clr_at == t);
      rx = (rerx_at == t);
      if (rx) u = W'(12345);
      tick();
      rx = 1'b0; borrar = 1'b0;
      if (r2[0]) begin seen = 1; ya = yo[0]; yb = yo[1]; lat = t + 1; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL rx_2_timeout: got no pulse expected pulse within 20 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    longint ya, yb, prev;
    int lat, bn, pulses;
    rst = 1'b1; tick(); tick();
    chk("reset_rx_2", r2[0], 0);
    chk("reset_y", yo[0], 0);
    chk("reset_ocupado", oc[0], 0);
    rst = 1'b0;

    send(ONE, -1, -1, ya, yb, lat, bn);
    chk("step1_y", ya, 64225);
    chk("step1_latency", lat, 6);
    chk("step1_busy", bn, 5);
    chk("step1_y_b0x2", yb, 131072);
    send(ONE, -1, -1, ya, yb, lat, bn);
    chk("step2_y", ya, 62940);
    chk("step2_busy", bn, 5);

    do_reset();
    send(ONE, -1, 2, ya, yb, lat, bn);
    chk("rerx_step1_y", ya, 64225);
    chk("rerx_latency", lat, 6);
    send(ONE, -1, -1, ya, yb, lat, bn);
    chk("rerx_step2_y", ya, 62940);

    do_reset();
    prev = 64'sd1 <<< 40;
    for (int i = 0; i < 200; i++) begin
      send(ONE, -1, -1, ya, yb, lat, bn);
      chk($sformatf("decay_mono_%0d", i), (ya <= prev), 1);
      chk($sformatf("decay_nonneg_%0d", i), (ya >= 0), 1);
      prev = ya;
    end

    do_reset();
    repeat (3) send(ONE, -1, -1, ya, yb, lat, bn);
    send(ONE, 0, -1, ya, yb, lat, bn);
    chk("borrar_with_rx_y", ya, 64225);
    send(ONE, 3, -1, ya, yb, lat, bn);
    chk("borrar_busy_current_y", ya, 62940);
    send(ONE, -1, -1, ya, yb, lat, bn);
    chk("borrar_busy_next_y", ya, 64225);

    do_reset();
    send(UMAX, -1, -1, ya, yb, lat, bn);
    chk("sat_pos_y", yb, 16777215);
    send(UMIN, -1, -1, ya, yb, lat, bn);
    chk("sat_neg_y", yb, -16777216);

    do_reset();
    rx = 1'b1; u = ONE; tick();
    rx = 1'b0; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_y", yo[0], 0);
    chk("abort_ocupado", oc[0], 0);
    pulses = 0;
    repeat (10) begin
      if (r2[0]) pulses++;
      tick();
    end
    chk("abort_no_pulse", pulses, 0);
    send(ONE, -1, -1, ya, yb, lat, bn);
    chk("abort_next_y", ya, 64225);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
